// File: rtl/game_pkg.sv
// game_pkg: shared state/stage encodings, position width and 13-bit sum helper
// for the game-flow sequencer.
package game_pkg;

    localparam int POS_W = 12;

    typedef enum logic [2:0] {
        TITLE,
        PLAY,
        WIN,
        LOSE,
        RESPAWN
    } state_t;

    localparam logic [1:0] STAGE_TITLE = 2'd0;
    localparam logic [1:0] STAGE_PLAY  = 2'd1;
    localparam logic [1:0] STAGE_WIN   = 2'd2;
    localparam logic [1:0] STAGE_LOSE  = 2'd3;

    // One bit wider than a position so edge + size never wraps past 4095.
    function automatic logic [POS_W:0] add(input logic [POS_W-1:0] p, input int unsigned s);
        return {1'b0, p} + (POS_W + 1)'(s);
    endfunction

    // RESPAWN is shown to the overlay as part of play.
    function automatic logic [1:0] stage_of(input state_t s);
        return s == TITLE ? STAGE_TITLE : s == WIN ? STAGE_WIN : s == LOSE ? STAGE_LOSE : STAGE_PLAY;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// frame_timer: vsync rising-edge tick, per-second frame counter and round
// countdown with load (new round) and run (count this tick) controls.
module frame_timer #(
    parameter int FPS        = 60,
    parameter int TIME_LIMIT = 60
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       vsync_in,
    input  logic       load,
    input  logic       run,
    output logic       tick,
    output logic       expired,
    output logic [7:0] sec_left
);

    localparam int FW = $clog2(FPS + 1);

    logic          vsync_q;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]    sec_left_q, sec_left_d;
    logic          wrap;

    always_comb begin
        tick        = vsync_in & ~vsync_q;
        wrap        = frame_cnt_q == FW'(FPS - 1);
        expired     = run && wrap && sec_left_q == 8'd1;
        frame_cnt_d = load ? '0 : run ? (wrap ? '0 : frame_cnt_q + FW'(1)) : frame_cnt_q;
        sec_left_d  = load ? 8'(TIME_LIMIT) : (run && wrap) ? sec_left_q - 8'd1 : sec_left_q;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            vsync_q     <= 1'b0;
            frame_cnt_q <= '0;
            sec_left_q  <= 8'(TIME_LIMIT);
        end else begin
            vsync_q     <= vsync_in;
            frame_cnt_q <= frame_cnt_d;
            sec_left_q  <= sec_left_d;
        end
    end

    assign sec_left = sec_left_q;

endmodule

// File: rtl/game_flow_ctl.sv
// game_flow_ctl: title/play/win/lose sequencer with per-frame collision, goal
// and countdown checks. Define GAME_LIVES_EN for multi-life rounds with RESPAWN.
module game_flow_ctl
    import game_pkg::*;
#(
    parameter int USER_SIZE   = 16,
    parameter int OBST_SIZE   = 32,
    parameter int GOAL_X      = 736,
    parameter int GOAL_Y      = 536,
    parameter int GOAL_SIZE   = 48,
    parameter int TIME_LIMIT  = 60,
    parameter int FPS         = 60,
    parameter int HOLD_FRAMES = 120
`ifdef GAME_LIVES_EN
    ,
    parameter int LIVES       = 3
`endif
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             vsync_in,
    input  logic [3:0]       keys,
    input  logic [POS_W-1:0] user_xpos,
    input  logic [POS_W-1:0] user_ypos,
    input  logic [POS_W-1:0] obst_xpos,
    input  logic [POS_W-1:0] obst_ypos,
    output logic [1:0]       game_stage,
    output logic             play_en,
    output logic             user_pos_rst,
    output logic             text_en,
    output logic [7:0]       sec_left,
    output logic [1:0]       lives_left
);

    localparam int HW = $clog2(HOLD_FRAMES + 1);

    state_t        state_q, state_d;
    logic [3:0]    keys_q;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]    game_stage_q;
    logic          play_en_q, text_en_q, user_pos_rst_q, user_pos_rst_d;
    logic          key_edge, hit, goal, hold_done, tick, expired, load, run;

    frame_timer #(
        .FPS       (FPS),
        .TIME_LIMIT(TIME_LIMIT)
    ) u_timer (
        .pclk    (pclk),
        .rst     (rst),
        .vsync_in(vsync_in),
        .load    (load),
        .run     (run),
        .tick    (tick),
        .expired (expired),
        .sec_left(sec_left)
    );

`ifdef GAME_LIVES_EN
    logic [1:0] lives_q, lives_d;
    assign lives_left = lives_q;
`else
    assign lives_left = 2'd1;
`endif

    always_comb begin
        key_edge  = |(keys & ~keys_q);
        hit       = add(user_xpos, 0) < add(obst_xpos, OBST_SIZE) && add(obst_xpos, 0) < add(user_xpos, USER_SIZE)
                 && add(user_ypos, 0) < add(obst_ypos, OBST_SIZE) && add(obst_ypos, 0) < add(user_ypos, USER_SIZE);
        goal      = add(user_xpos, 0) >= add('0, GOAL_X) && add(user_xpos, USER_SIZE) <= add('0, GOAL_X + GOAL_SIZE)
                 && add(user_ypos, 0) >= add('0, GOAL_Y) && add(user_ypos, USER_SIZE) <= add('0, GOAL_Y + GOAL_SIZE);
        hold_done = hold_cnt_q >= HW'(HOLD_FRAMES);
        load      = state_q == TITLE && key_edge;
        run       = state_q == PLAY && tick && !hit && !goal;
        state_d        = state_q;
        hold_cnt_d     = hold_cnt_q;
        user_pos_rst_d = 1'b0;
`ifdef GAME_LIVES_EN
        lives_d        = lives_q;
`endif
        case (state_q)
            TITLE: if (key_edge) begin
                state_d        = PLAY;
                user_pos_rst_d = 1'b1;
`ifdef GAME_LIVES_EN
                lives_d        = 2'(LIVES);
`endif
            end
            PLAY: begin
                hold_cnt_d = '0;
                if (tick && hit) begin
`ifdef GAME_LIVES_EN
                    state_d        = lives_q > 2'd1 ? RESPAWN : LOSE;
                    user_pos_rst_d = lives_q > 2'd1;
                    lives_d        = lives_q - 2'd1;
`else
                    state_d = LOSE;
`endif
                end else if (tick && goal) state_d = WIN;
                else if (expired) state_d = LOSE;
            end
`ifdef GAME_LIVES_EN
            RESPAWN: if (tick) begin
                hold_cnt_d = hold_cnt_q + HW'(1);
                if (hold_cnt_q >= HW'(HOLD_FRAMES - 1)) state_d = PLAY;
            end
`endif
            default: begin
                if (hold_done && key_edge) state_d = TITLE;
                else if (tick && !hold_done) hold_cnt_d = hold_cnt_q + HW'(1);
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q        <= TITLE;
            keys_q         <= '0;
            hold_cnt_q     <= '0;
            game_stage_q   <= STAGE_TITLE;
            play_en_q      <= 1'b0;
            text_en_q      <= 1'b1;
            user_pos_rst_q <= 1'b0;
`ifdef GAME_LIVES_EN
            lives_q        <= 2'(LIVES);
`endif
        end else begin
            state_q        <= state_d;
            keys_q         <= keys;
            hold_cnt_q     <= hold_cnt_d;
            game_stage_q   <= stage_of(state_d);
            play_en_q      <= state_d == PLAY;
            text_en_q      <= state_d inside {TITLE, WIN, LOSE};
            user_pos_rst_q <= user_pos_rst_d;
`ifdef GAME_LIVES_EN
            lives_q        <= lives_d;
`endif
        end
    end

    assign game_stage   = game_stage_q;
    assign play_en      = play_en_q;
    assign text_en      = text_en_q;
    assign user_pos_rst = user_pos_rst_q;

endmodule
